// File: rtl/button_pulse_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_pulse_gen_if
// Description : Signal bundle between a push-button source and the
//               debounce/pulse generator.
//                 buttonIn    raw pushbutton level, asynchronous, 1 = pressed
//                 buttonReg   one-cycle pulse per accepted press
//                 buttonLevel debounced level, 1 = pressed
//               master : button side (drives buttonIn, observes outputs)
//               slave  : generator side (button_pulse_gen)
// Revision    : 1.0 - initial release
// ============================================================================
interface button_pulse_gen_if;
  logic buttonIn;
  logic buttonReg;
  logic buttonLevel;

  modport master (
    output buttonIn,
    input  buttonReg,
    input  buttonLevel
  );

  modport slave (
    input  buttonIn,
    output buttonReg,
    output buttonLevel
  );
endinterface
`default_nettype wire

// File: rtl/button_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_pulse_gen
// Description : Synchronises and debounces a raw push-button level and emits
//               exactly one single-cycle buttonReg pulse per confirmed press
//               (the increment enable of a downstream counter). Also exports
//               the registered debounced level.
// Ports       : clock        in   system clock, all logic on posedge
//               resetN       in   synchronous, active-low reset
//               btn.buttonIn in   raw pushbutton level (asynchronous)
//               btn.buttonReg out registered one-cycle press pulse
//               btn.buttonLevel out registered debounced level
// Parameters  : DEBOUNCE_CYCLES  stable cycles to confirm press/release (>=2)
//               REPEAT_DELAY     hold cycles before first auto-repeat (>=1)
//               REPEAT_RATE      cycles between later auto-repeats (>=1)
// Macro       : AUTO_REPEAT_EN   enables auto-repeat pulses while held
// Revision    : 1.0 - initial release
// ============================================================================
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  wire logic         clock,
  input  wire logic         resetN,
  button_pulse_gen_if.slave btn
);

  // Counters are sized for the largest terminal count of any timer.
  localparam int c_MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int c_MAX_ALL = (c_MAX_DR > REPEAT_RATE) ? c_MAX_DR : REPEAT_RATE;
  localparam int CNT_W     = $clog2(c_MAX_ALL + 1);

  localparam logic [CNT_W-1:0] c_CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_q;
  logic             s2_q;
  logic             pulse_q;
  logic             level_q;

  // Saturating increment: a counter parked at all-ones never wraps to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_CNT_SAT) ? v : v + 1'b1;
  endfunction

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rep_q;
  // 0 while waiting for the first repeat, 1 once in the periodic phase.
  logic             rep_phase_q;
`endif

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      pulse_q     <= 1'b0;
      level_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      s1_q    <= btn.buttonIn;
      s2_q    <= s1_q;
      // Pulse is one cycle wide unless a branch below re-asserts it.
      pulse_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      // Repeat timer only runs in HELD; any other cycle clears it.
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == c_DB_LAST) begin
            state_q <= HELD;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= sat_inc(cnt_q);
          end
        end

        HELD: begin
          if (!s2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_W'(1);
          end
`ifdef AUTO_REPEAT_EN
          else begin
            if (rep_q == (rep_phase_q ? c_RR_LAST : c_RD_LAST)) begin
              pulse_q     <= 1'b1;
              rep_q       <= '0;
              rep_phase_q <= 1'b1;
            end else begin
              rep_q       <= sat_inc(rep_q);
              rep_phase_q <= rep_phase_q;
            end
          end
`endif
        end

        RELEASE_WAIT: begin
          if (s2_q) begin
            // Release bounce: go back to HELD without a new pulse.
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == c_DB_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= sat_inc(cnt_q);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn.buttonReg   = pulse_q;
  assign btn.buttonLevel = level_q;

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_button_pulse_gen
// Description : Directed bench for button_pulse_gen with DEBOUNCE_CYCLES=4,
//               REPEAT_DELAY=10, REPEAT_RATE=3. Expected pulse cycles are
//               queued when stimulus is driven and matched as pulses appear.
//               Cycle numbers count rising edges; an input driven while the
//               count is k and held stable yields a pulse seen at count k+6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_pulse_gen;

  logic clock;
  logic resetN;
  int   cyc;
  int   n_asserts;
  int   n_fail;
  int   n_pulses;
  int   n_pushed;
  int   exp_q[$];
  bit   in_rst;
  logic prev_reg;

  button_pulse_gen_if btn_if ();

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .btn    (btn_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc    = cyc + 1;
    in_rst = !resetN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic push(input int c);
    exp_q.push_back(c);
    n_pushed++;
  endtask

  task automatic step_end(input string tag);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
    chk({tag, "_pulse_count"}, n_pulses, n_pushed);
  endtask

  task automatic chk_level(input string tag, input int c, input logic exp);
    at_cyc(c);
    chk(tag, btn_if.buttonLevel, exp);
  endtask

  // Scoreboard side: every pulse must match the head of the queue.
  always @(negedge clock) begin
    int exp_c;
    if (in_rst) begin
      chk("rst_reg", btn_if.buttonReg, 0);
      chk("rst_level", btn_if.buttonLevel, 0);
    end
    if (btn_if.buttonReg === 1'b1) begin
      n_pulses++;
      chk("no_back_to_back", prev_reg, 0);
      chk("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_c = exp_q.pop_front();
        chk("pulse_cycle", cyc, exp_c);
      end
    end
    prev_reg = btn_if.buttonReg;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc       = 0;
    n_asserts = 0;
    n_fail    = 0;
    n_pulses  = 0;
    n_pushed  = 0;
    in_rst    = 1'b0;
    prev_reg  = 1'b0;
    resetN    = 1'b0;
    btn_if.buttonIn = 1'b1;

    // 1: reset with button held, then release reset.
    at_cyc(3);
    chk("t1_rst_reg_explicit", btn_if.buttonReg, 0);
    chk("t1_rst_level_explicit", btn_if.buttonLevel, 0);
    resetN = 1'b1;
    push(9);
    chk_level("t1_level_before", 8, 1'b0);
    chk_level("t1_level_rise", 9, 1'b1);
    at_cyc(12);
    btn_if.buttonIn = 1'b0;
    chk_level("t1_level_hold", 17, 1'b1);
    chk_level("t1_level_fall", 18, 1'b0);
    at_cyc(22);
    step_end("t1");

    // 2: clean press held 20 cycles.
    at_cyc(25);
    btn_if.buttonIn = 1'b1;
    push(31);
`ifdef AUTO_REPEAT_EN
    push(41);
    push(44);
    push(47);
`endif
    chk_level("t2_level_before", 30, 1'b0);
    chk_level("t2_level_rise", 31, 1'b1);
    at_cyc(45);
    btn_if.buttonIn = 1'b0;
    chk_level("t2_level_hold", 50, 1'b1);
    chk_level("t2_level_fall", 51, 1'b0);
    at_cyc(56);
    step_end("t2");

    // 3: press bounce 1,0,1,0 then stable 1.
    at_cyc(60); btn_if.buttonIn = 1'b1;
    at_cyc(61); btn_if.buttonIn = 1'b0;
    at_cyc(62); btn_if.buttonIn = 1'b1;
    at_cyc(63); btn_if.buttonIn = 1'b0;
    at_cyc(64); btn_if.buttonIn = 1'b1;
    push(70);
    chk_level("t3_level_before", 69, 1'b0);
    chk_level("t3_level_rise", 70, 1'b1);

    // 4: release bounce of two cycles while held.
    at_cyc(74); btn_if.buttonIn = 1'b0;
    at_cyc(76); btn_if.buttonIn = 1'b1;
    for (int c = 75; c <= 81; c++) chk_level("t4_level_stays", c, 1'b1);
    at_cyc(82);
    btn_if.buttonIn = 1'b0;
    chk_level("t4_level_hold", 87, 1'b1);
    chk_level("t4_level_fall", 88, 1'b0);
    at_cyc(90);
    step_end("t3_t4");

    // 5: reset during PRESS_WAIT (cnt=2), then fresh debounce.
    at_cyc(92);
    btn_if.buttonIn = 1'b1;
    at_cyc(96);
    resetN = 1'b0;
    at_cyc(98);
    resetN = 1'b1;
    push(104);
    chk_level("t5_level_before", 103, 1'b0);
    chk_level("t5_level_rise", 104, 1'b1);
    at_cyc(108);
    btn_if.buttonIn = 1'b0;
    chk_level("t5_level_fall", 114, 1'b0);
    at_cyc(118);
    step_end("t5");

    // 6: long hold; repeats only when auto-repeat is built in.
    at_cyc(120);
    btn_if.buttonIn = 1'b1;
    push(126);
`ifdef AUTO_REPEAT_EN
    for (int p = 136; p < 159; p += 3) push(p);
`endif
    chk_level("t6_level_rise", 126, 1'b1);
    at_cyc(156);
    btn_if.buttonIn = 1'b0;
    chk_level("t6_level_hold", 161, 1'b1);
    chk_level("t6_level_fall", 162, 1'b0);
    at_cyc(170);
    step_end("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
